// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file writeback path.
//   XLEN       : result / register width
//   NREGS      : number of architectural registers
//   REG_ADDR_W : register address width
//   wb_entry_t : one buffered writeback (destination register + data)
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_chk.sv
// Protocol checker for regfile_writeback.
// Ports: clock, reset, both result handshakes and fifo_count, all observed.
// Flags a handshake accepted while the buffer is full and an occupancy count
// beyond DEPTH.
module regfile_writeback_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clock,
  input logic                   reset,
  input logic                   alu_valid,
  input logic                   alu_ready,
  input logic                   lsu_valid,
  input logic                   lsu_ready,
  input logic [$clog2(DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  a_no_push_when_full: assert property (
    @(posedge clock) disable iff (reset)
    (fifo_count == CNT_W'(DEPTH)) |-> !(alu_valid && alu_ready) && !(lsu_valid && lsu_ready)
  );

  a_count_bounded: assert property (
    @(posedge clock) disable iff (reset)
    fifo_count <= CNT_W'(DEPTH)
  );

endmodule

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   push, push_entry   : write push_entry at the tail (ignored while full)
//   pop                : drop the head entry (ignored while empty)
//   head               : current head entry (meaningful only when !empty)
//   full, empty, count : occupancy status
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  // A push is refused while full even if a pop happens in the same cycle.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writer side of the register file.
// Collects results from the ALU and the load unit (load has fixed priority),
// buffers them in order and drains one per cycle onto the single register
// file write port. A busy-bit scoreboard tracks pending writes for decode.
// Ports:
//   clock, reset                    : clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/...  : ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/...  : load result handshake
//   issue_valid, issue_rd           : decode issued a writer of issue_rd
//   rf_we, rf_rd, rf_wdata          : register file write port
//   busy_mask                       : bit i set while a write to reg i pends
//   fifo_count                      : entries currently buffered
// XLEN/NREGS must match the cpu_pkg values the entry struct is built from.
module regfile_writeback #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]               lsu_data,
  input  logic                          issue_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] issue_rd,
  output logic                          rf_we,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [NREGS-1:0]              busy_mask,
  output logic [$clog2(DEPTH):0]        fifo_count
);

  import cpu_pkg::*;

  wb_entry_t        push_entry_s;
  wb_entry_t        head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic [NREGS-1:0] busy_next_s;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (fifo_count)
  );

  // Enqueue arbitration: load unit wins over the ALU
  always_comb begin
    lsu_ready    = !full_s;
    alu_ready    = !full_s && !lsu_valid;
    push_s       = 1'b0;
    push_entry_s = '0;
    if (lsu_valid && !full_s) begin
      push_s            = 1'b1;
      push_entry_s.rd   = lsu_rd;
      push_entry_s.data = lsu_data;
    end else if (alu_valid && alu_ready) begin
      push_s            = 1'b1;
      push_entry_s.rd   = alu_rd;
      push_entry_s.data = alu_data;
    end else begin
      push_s       = 1'b0;
      push_entry_s = '0;
    end
  end

  // The register file never stalls, so the head drains every non-empty cycle
  assign pop_s = !empty_s;

  // Write port: head drives the port; x0 entries drain silently
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = REG_ADDR_W'(0);
    rf_wdata = XLEN'(0);
    if (!empty_s) begin
      rf_we    = (head_s.rd != REG_ADDR_W'(0));
      rf_rd    = head_s.rd;
      rf_wdata = head_s.data;
    end else begin
      rf_we    = 1'b0;
      rf_rd    = REG_ADDR_W'(0);
      rf_wdata = XLEN'(0);
    end
  end

  // Scoreboard next state: clear on drain, then set on issue so a same-cycle
  // issue of the draining register stays busy (the newer writer pends)
  always_comb begin
    clr_mask_s  = pop_s ? (NREGS'(1) << head_s.rd) : NREGS'(0);
    set_mask_s  = (issue_valid && (issue_rd != REG_ADDR_W'(0)))
                  ? (NREGS'(1) << issue_rd) : NREGS'(0);
    busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~NREGS'(1);
  end

  // Scoreboard register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r <= NREGS'(0);
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy_mask = busy_r;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int DEPTH = 4;

  logic              clock;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              rf_we;
  logic [4:0]        rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic [NREGS-1:0]  busy_mask;
  logic [2:0]        fifo_count;

  regfile_writeback #(.XLEN(XLEN), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask),
    .fifo_count  (fifo_count)
  );

  regfile_writeback_chk #(.DEPTH(DEPTH)) u_chk (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .fifo_count (fifo_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: pending results in arrival order plus a pending-write set
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] model_busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every observable output against the model's current state
  task automatic check_model(input logic lv);
    bit          full_m;
    bit          has_head;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    full_m    = (model_q.size() == DEPTH);
    has_head  = (model_q.size() > 0);
    head_rd   = has_head ? model_q[0].rd : 5'd0;
    head_data = has_head ? model_q[0].data : 32'd0;
    check("lsu_ready", 64'(lsu_ready), 64'(!full_m));
    check("alu_ready", 64'(alu_ready), 64'(!full_m && !lv));
    check("rf_we", 64'(rf_we), 64'(has_head && head_rd != 5'd0));
    check("rf_rd", 64'(rf_rd), 64'(head_rd));
    check("rf_wdata", 64'(rf_wdata), 64'(head_data));
    check("busy_mask", 64'(busy_mask), 64'(model_busy));
    check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
  endtask

  // One clock cycle: drive on the falling edge, check, then advance the model
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    bit   full_m;
    ent_t e;
    @(negedge clock);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    #1;
    check_model(lv);
    @(posedge clock);
    full_m = (model_q.size() == DEPTH);
    if (model_q.size() > 0) begin
      model_busy[model_q[0].rd] = 1'b0;
      void'(model_q.pop_front());
    end
    if (!full_m && lv) begin
      e.rd = lrd; e.data = ld; model_q.push_back(e);
    end else if (!full_m && av) begin
      e.rd = ard; e.data = ad; model_q.push_back(e);
    end
    if (iv) model_busy[ird] = 1'b1;
    model_busy[0] = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_busy = 32'd0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    #1;
    check("reset rf_we", 64'(rf_we), 64'd0);
    check("reset fifo_count", 64'(fifo_count), 64'd0);
    check("reset busy_mask", 64'(busy_mask), 64'd0);
    check("reset rf_rd", 64'(rf_rd), 64'd0);
    check("reset rf_wdata", 64'(rf_wdata), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single ALU result
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    check("t1 rf_we", 64'(rf_we), 64'd1);
    check("t1 rf_rd", 64'(rf_rd), 64'd5);
    check("t1 rf_wdata", 64'(rf_wdata), 64'h1234);
    idle();
    #1;
    check("t1 count drained", 64'(fifo_count), 64'd0);

    // ALU and LSU together: load first, ALU holds and goes next
    cycle(1'b1, 5'd2, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0, 5'd0);
    #1;
    check("t2 first rd", 64'(rf_rd), 64'd3);
    check("t2 first data", 64'(rf_wdata), 64'hB);
    cycle(1'b1, 5'd2, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    check("t2 second rd", 64'(rf_rd), 64'd2);
    check("t2 second data", 64'(rf_wdata), 64'hA);
    idle();

    // Streaming: one result per cycle never builds up more than one entry
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 5'd0);
      #1;
      check("t3 count", 64'(fifo_count), 64'd1);
    end
    idle();

    // Write to x0 is buffered but never enables the write port
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    check("t4 count", 64'(fifo_count), 64'd1);
    check("t4 rf_we", 64'(rf_we), 64'd0);
    idle();
    #1;
    check("t4 drained", 64'(fifo_count), 64'd0);

    // Scoreboard set, clear and set-wins
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    #1;
    check("t5 busy set", 64'(busy_mask[7]), 64'd1);
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    #1;
    check("t5 busy cleared", 64'(busy_mask[7]), 64'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cycle(1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    #1;
    check("t5 set wins", 64'(busy_mask[7]), 64'd1);
    cycle(1'b1, 5'd7, 32'h79, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    #1;
    check("t5 final clear", 64'(busy_mask[7]), 64'd0);

    // Asynchronous reset with a result queued
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    #1;
    check("t6 queued", 64'(fifo_count), 64'd1);
    alu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("t6 async rf_we", 64'(rf_we), 64'd0);
    check("t6 async count", 64'(fifo_count), 64'd0);
    check("t6 async busy", 64'(busy_mask), 64'd0);
    model_q.delete();
    model_busy = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    idle();
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom,
            1'($urandom_range(3, 0) == 0), 5'($urandom_range(31, 0)), $urandom,
            1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
